// File: rtl/cdb_rr_arbiter.sv
// rtl/cdb_rr_arbiter.sv - buffered round-robin CDB arbiter, optional statistics under CDB_STATS_EN
module cdb_rr_arbiter #(
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ALU_cdb_request,
    input  logic [TAG_W+DATA_W-1:0] ALU_cdb_in,
    output logic                    ALU_cdb_accept,
    input  logic                    mul_cdb_request,
    input  logic [TAG_W+DATA_W-1:0] mul_cdb_in,
    output logic                    mul_cdb_accept,
    input  logic                    div_cdb_request,
    input  logic [TAG_W+DATA_W-1:0] div_cdb_in,
    output logic                    div_cdb_accept,
    input  logic                    ls_cdb_request,
    input  logic [TAG_W+DATA_W-1:0] ls_cdb_in,
    output logic                    ls_cdb_accept,
    output logic [TAG_W+DATA_W:0]   cdb,
    output logic [3:0]              slot_busy,
    input  logic [1:0]              stat_sel,
    output logic [STAT_W-1:0]       stat_grants,
    output logic [STAT_W-1:0]       stat_stalls
);
    localparam int PW = TAG_W + DATA_W;

    logic [3:0]    w_req;
    logic [PW-1:0] w_pay [4];
    logic [3:0]    w_accept;
    logic [3:0]    w_capture;
    logic [3:0]    w_drain;
    logic [1:0]    w_winner;
    logic [1:0]    w_idx;
    logic          w_any;

    logic [PW-1:0] r_slot [4];
    logic [3:0]    r_slot_valid;
    logic [1:0]    r_ptr;
    logic [PW:0]   r_cdb;

    assign w_req    = {ls_cdb_request, div_cdb_request, mul_cdb_request, ALU_cdb_request};
    assign w_pay[0] = ALU_cdb_in;
    assign w_pay[1] = mul_cdb_in;
    assign w_pay[2] = div_cdb_in;
    assign w_pay[3] = ls_cdb_in;

    // Pick the first occupied slot at or after the round-robin pointer
    always_comb begin
        w_drain  = '0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        w_any    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + k[1:0];
            if (!w_any && r_slot_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
        if (w_any) begin
            w_drain[w_winner] = 1'b1;
        end
    end

    // A slot accepts when empty or when it is being drained this cycle; a null tag is accepted but never stored
    always_comb begin
        w_accept  = '0;
        w_capture = '0;
        for (int i = 0; i < 4; i++) begin
            w_accept[i]  = w_req[i] & (~r_slot_valid[i] | w_drain[i]) & ~rst;
            w_capture[i] = w_accept[i] & (w_pay[i][PW-1 -: TAG_W] != '0);
        end
    end

    // Slot capture/clear, pointer advance and registered broadcast
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_valid <= '0;
            r_ptr        <= '0;
            r_cdb        <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_capture[i]) begin
                    r_slot[i]       <= w_pay[i];
                    r_slot_valid[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_slot_valid[i] <= 1'b0;
                end
            end
            if (w_any) begin
                r_cdb <= {1'b1, r_slot[w_winner]};
                r_ptr <= w_winner + 2'd1;
            end else begin
                r_cdb <= '0;
            end
        end
    end

    assign ALU_cdb_accept = w_accept[0];
    assign mul_cdb_accept = w_accept[1];
    assign div_cdb_accept = w_accept[2];
    assign ls_cdb_accept  = w_accept[3];
    assign cdb            = r_cdb;
    assign slot_busy      = r_slot_valid;

`ifdef CDB_STATS_EN
    logic [STAT_W-1:0] r_grants [4];
    logic [STAT_W-1:0] r_stalls [4];

    // Saturating per-unit grant and stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_grants[i] <= '0;
                r_stalls[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_drain[i] && (r_grants[i] != {STAT_W{1'b1}})) begin
                    r_grants[i] <= r_grants[i] + 1'b1;
                end
                if (r_slot_valid[i] && !w_drain[i] && (r_stalls[i] != {STAT_W{1'b1}})) begin
                    r_stalls[i] <= r_stalls[i] + 1'b1;
                end
            end
        end
    end

    assign stat_grants = r_grants[stat_sel];
    assign stat_stalls = r_stalls[stat_sel];
`else
    logic w_unused_sel;

    assign w_unused_sel = ^stat_sel;
    assign stat_grants  = '0;
    assign stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// tb/tb_cdb_rr_arbiter.sv - scoreboard bench for cdb_rr_arbiter against a queue-level reference model
module tb_cdb_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] pay [4];
    logic [3:0]  acc;
    logic [40:0] cdb;
    logic [3:0]  slot_busy;
    logic [1:0]  stat_sel;
    logic [15:0] stat_grants;
    logic [15:0] stat_stalls;

    always #5 clk = ~clk;

    cdb_rr_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .ALU_cdb_request (req[0]),
        .ALU_cdb_in      (pay[0]),
        .ALU_cdb_accept  (acc[0]),
        .mul_cdb_request (req[1]),
        .mul_cdb_in      (pay[1]),
        .mul_cdb_accept  (acc[1]),
        .div_cdb_request (req[2]),
        .div_cdb_in      (pay[2]),
        .div_cdb_accept  (acc[2]),
        .ls_cdb_request  (req[3]),
        .ls_cdb_in       (pay[3]),
        .ls_cdb_accept   (acc[3]),
        .cdb             (cdb),
        .slot_busy       (slot_busy),
        .stat_sel        (stat_sel),
        .stat_grants     (stat_grants),
        .stat_stalls     (stat_stalls)
    );

    // Reference model: each unit owns at most one pending entry, pointer is an integer 0..3
    bit          m_full [4];
    logic [39:0] m_val [4];
    int          m_ptr;
    int          m_grants [4];
    int          m_stalls [4];
    bit   [3:0]  last_acc;

    typedef struct {
        logic [39:0] p;
        int          due;
    } exp_t;
    exp_t sb[$];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int mode [4];   // 0 idle, 1 one-shot, 2 continuous incrementing, 3 random

    function automatic int m_winner();
        for (int k = 0; k < 4; k++) begin
            if (m_full[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [39:0] rand_pay();
        logic [7:0] t;
        t = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        return {t, 32'($urandom)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i]   = 1'b0;
            m_grants[i] = 0;
            m_stalls[i] = 0;
        end
        m_ptr = 0;
    endtask

    // One clock: check accept/occupancy before the edge, then advance the model at the edge
    task automatic step();
        int w;
        bit [3:0] ea;
        @(negedge clk);
        w  = m_winner();
        ea = '0;
        for (int i = 0; i < 4; i++) begin
            ea[i] = req[i] && !rst && (!m_full[i] || (i == w));
        end
        last_acc = ea;
        total++;
        if (acc !== ea) begin
            bad++;
            $display("FAIL accept cyc=%0d got=%b want=%b", cyc, acc, ea);
        end
        total++;
        if (slot_busy !== {m_full[3], m_full[2], m_full[1], m_full[0]}) begin
            bad++;
            $display("FAIL slot_busy cyc=%0d got=%b want=%b", cyc, slot_busy,
                     {m_full[3], m_full[2], m_full[1], m_full[0]});
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_full[i] && i != w && m_stalls[i] < 65535) m_stalls[i]++;
            end
            if (w >= 0) begin
                sb.push_back('{m_val[w], cyc + 1});
                if (m_grants[w] < 65535) m_grants[w]++;
                m_full[w] = 1'b0;
                m_ptr     = (w + 1) % 4;
            end
            for (int i = 0; i < 4; i++) begin
                if (ea[i] && pay[i][39:32] != 8'h00) begin
                    m_full[i] = 1'b1;
                    m_val[i]  = pay[i];
                end
            end
        end
        cyc++;
        #1;
    endtask

    // Unit behaviour after an edge: hold while refused, move on once accepted
    task automatic advance();
        for (int i = 0; i < 4; i++) begin
            case (mode[i])
                1: if (req[i] && last_acc[i]) req[i] = 1'b0;
                2: if (req[i] && last_acc[i]) pay[i][31:0] = pay[i][31:0] + 32'd1;
                3: begin
                    if (!req[i] || last_acc[i]) begin
                        req[i] = $urandom_range(0, 1) == 1;
                        pay[i] = rand_pay();
                    end
                end
                default: req[i] = 1'b0;
            endcase
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            advance();
        end
    endtask

    task automatic check_stat(input string nm, input logic [15:0] got, input int want);
        total++;
        if (got !== 16'(want)) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Monitor: every visible broadcast must match the oldest expected one, on its due cycle
    initial begin
        forever begin
            @(negedge clk);
            if (cdb[40]) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL cdb_spurious cyc=%0d got=%h want=none", cyc, cdb);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (cdb[39:0] !== e.p || e.due != cyc) begin
                        bad++;
                        $display("FAIL cdb_value cyc=%0d got=%h want=%h due=%0d", cyc, cdb[39:0], e.p, e.due);
                    end
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL cdb_missing cyc=%0d got=%h want=%h", cyc, cdb, e.p);
            end else if (cdb !== 41'b0) begin
                total++;
                bad++;
                $display("FAIL cdb_idle cyc=%0d got=%h want=0", cyc, cdb);
            end
        end
    end

    initial begin
        stat_sel = 2'd0;
        model_reset();
        for (int i = 0; i < 4; i++) mode[i] = 0;

        // Reset held with all units requesting
        rst    = 1'b1;
        req    = 4'hF;
        pay[0] = 40'h81_0000_0001;
        pay[1] = 40'h91_0000_0002;
        pay[2] = 40'hA1_0000_0003;
        pay[3] = 40'hB1_0000_0004;
        #1;
        step();
        step();
        rst = 1'b0;
        req = 4'h0;

        // Single ALU result
        mode[0] = 1;
        req[0]  = 1'b1;
        pay[0]  = 40'h81_0000_0050;
        run(4);

        // Four-way burst twice, counters freshly cleared
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) mode[i] = 1;
            req    = 4'hF;
            pay[0] = {8'h81, 32'(b)};
            pay[1] = {8'h91, 32'(b)};
            pay[2] = {8'hA1, 32'(b)};
            pay[3] = {8'hB1, 32'(b)};
            run(6);
        end
`ifdef CDB_STATS_EN
        stat_sel = 2'd3;
        #1;
        check_stat("fourway_grants", stat_grants, 2);
        check_stat("fourway_stalls", stat_stalls, 6);
`else
        stat_sel = 2'd3;
        #1;
        check_stat("grants_off", stat_grants, 0);
        check_stat("stalls_off", stat_stalls, 0);
`endif

        // Continuous ls and div traffic: slots alternate and ls sees backpressure
        mode[2] = 2;
        mode[3] = 2;
        req[2]  = 1'b1;
        req[3]  = 1'b1;
        pay[2]  = 40'hA1_0000_1000;
        pay[3]  = 40'hB1_0000_2000;
        run(12);
        mode[2] = 0;
        mode[3] = 0;
        req     = 4'h0;
        run(4);

        // Null tag is accepted and dropped
        mode[1] = 1;
        req[1]  = 1'b1;
        pay[1]  = 40'h00_0000_1234;
        run(4);

        // Random traffic with a reset in the middle
        for (int i = 0; i < 4; i++) mode[i] = 3;
        run(150);
        rst = 1'b1;
        step();
        advance();
        rst = 1'b0;
        run(250);

        // Quiesce and confirm nothing is left outstanding
        for (int i = 0; i < 4; i++) mode[i] = 0;
        req = 4'h0;
        run(8);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end

`ifdef CDB_STATS_EN
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            #1;
            check_stat("rand_grants", stat_grants, m_grants[s]);
            check_stat("rand_stalls", stat_stalls, m_stalls[s]);
        end
`else
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            #1;
            check_stat("grants_off", stat_grants, 0);
            check_stat("stalls_off", stat_stalls, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
